// File: rtl/regfile_cmd_entry_if.sv
// Command-entry bus between the switch/button front panel and the register-file command generator.
// The btn_abort line exists only when CMD_ENTRY_ABORT_EN is defined.
interface regfile_cmd_entry_if;
    logic [3:0]  sw;
    logic        btn;
`ifdef CMD_ENTRY_ABORT_EN
    logic        btn_abort;
`endif
    logic [1:0]  mode;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [4:0]  raA;
    logic [4:0]  raB;
    logic        we;
    logic        busy;

    modport master (
        output sw, btn,
`ifdef CMD_ENTRY_ABORT_EN
        output btn_abort,
`endif
        input  mode, wa, wd, raA, raB, we, busy
    );

    modport slave (
        input  sw, btn,
`ifdef CMD_ENTRY_ABORT_EN
        input  btn_abort,
`endif
        output mode, wa, wd, raA, raB, we, busy
    );
endinterface

// File: rtl/regfile_cmd_entry.sv
// Switch/pushbutton command entry for the register file: write, single read or dual read.
// Optional abort button enabled by defining CMD_ENTRY_ABORT_EN.
module regfile_cmd_entry_deb #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s_q, db_q, db_d, press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s_q     <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s_q     <= s1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= db_d & ~db_q;
        end
    end

    assign press_o = press_q;
endmodule

module regfile_cmd_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_cmd_entry_if.slave   bus
);
    localparam logic [3:0] S_ACCEPT  = 4'd0;
    localparam logic [3:0] S_A_HI    = 4'd1;
    localparam logic [3:0] S_A_LO    = 4'd2;
    localparam logic [3:0] S_D3      = 4'd3;
    localparam logic [3:0] S_D2      = 4'd4;
    localparam logic [3:0] S_D1      = 4'd5;
    localparam logic [3:0] S_D0      = 4'd6;
    localparam logic [3:0] S_WRITE   = 4'd7;
    localparam logic [3:0] S_SHOW_W  = 4'd8;
    localparam logic [3:0] S_B_HI    = 4'd9;
    localparam logic [3:0] S_B_LO    = 4'd10;
    localparam logic [3:0] S_SHOW_R1 = 4'd11;
    localparam logic [3:0] S_SHOW_R2 = 4'd12;

    logic [3:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  wa_q, wa_d, raA_q, raA_d, raB_q, raB_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  mode_q;
    logic        we_q;
    logic        press;
    logic        abort_press;

    function automatic logic [1:0] mode_of(input logic [3:0] st);
        case (st)
            S_WRITE, S_SHOW_W: mode_of = 2'b01;
            S_SHOW_R1:         mode_of = 2'b10;
            S_SHOW_R2:         mode_of = 2'b11;
            default:           mode_of = 2'b00;
        endcase
    endfunction

    function automatic logic is_entry(input logic [3:0] st);
        is_entry = (st == S_A_HI) || (st == S_A_LO) || (st == S_D3) || (st == S_D2) ||
                   (st == S_D1) || (st == S_D0) || (st == S_B_HI) || (st == S_B_LO);
    endfunction

    regfile_cmd_entry_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_btn (
        .clk(clk), .rst(rst), .raw_i(bus.btn), .press_o(press)
    );

`ifdef CMD_ENTRY_ABORT_EN
    regfile_cmd_entry_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_abort (
        .clk(clk), .rst(rst), .raw_i(bus.btn_abort), .press_o(abort_press)
    );
`else
    assign abort_press = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        raA_d   = raA_q;
        raB_d   = raB_q;
        // Abort beats a coincident button press, so no capture happens on that edge.
        if (abort_press && is_entry(state_q)) begin
            state_d = S_ACCEPT;
        end else begin
            case (state_q)
                S_ACCEPT: if (press) begin
                    op_d = bus.sw[1:0];
                    if (bus.sw[1:0] != 2'b00) state_d = S_A_HI;
                end
                S_A_HI: if (press) begin
                    if (op_q == 2'b01) wa_d[4] = bus.sw[0];
                    else               raA_d[4] = bus.sw[0];
                    state_d = S_A_LO;
                end
                S_A_LO: if (press) begin
                    if (op_q == 2'b01) begin
                        wa_d[3:0] = bus.sw;
                        state_d   = S_D3;
                    end else begin
                        raA_d[3:0] = bus.sw;
                        state_d    = (op_q == 2'b10) ? S_SHOW_R1 : S_B_HI;
                    end
                end
                S_D3: if (press) begin
                    wd_d[15:12] = bus.sw;
                    state_d     = S_D2;
                end
                S_D2: if (press) begin
                    wd_d[11:8] = bus.sw;
                    state_d    = S_D1;
                end
                S_D1: if (press) begin
                    wd_d[7:4] = bus.sw;
                    state_d   = S_D0;
                end
                S_D0: if (press) begin
                    wd_d[3:0] = bus.sw;
                    state_d   = S_WRITE;
                end
                S_WRITE: state_d = S_SHOW_W;
                S_B_HI: if (press) begin
                    raB_d[4] = bus.sw[0];
                    state_d  = S_B_LO;
                end
                S_B_LO: if (press) begin
                    raB_d[3:0] = bus.sw;
                    state_d    = S_SHOW_R2;
                end
                S_SHOW_W, S_SHOW_R1, S_SHOW_R2: if (press) state_d = S_ACCEPT;
                default: state_d = S_ACCEPT;
            endcase
        end
    end

    // mode and we are registered from the next state so they line up with state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACCEPT;
            op_q    <= 2'b00;
            wa_q    <= '0;
            wd_q    <= '0;
            raA_q   <= '0;
            raB_q   <= '0;
            mode_q  <= 2'b00;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            raA_q   <= raA_d;
            raB_q   <= raB_d;
            mode_q  <= mode_of(state_d);
            we_q    <= (state_d == S_WRITE);
        end
    end

    assign bus.mode = mode_q;
    assign bus.wa   = wa_q;
    assign bus.wd   = wd_q;
    assign bus.raA  = raA_q;
    assign bus.raB  = raB_q;
    assign bus.we   = we_q;
    assign bus.busy = (state_q != S_ACCEPT);
endmodule

// File: tb/tb_regfile_cmd_entry.sv
// Self-checking bench for regfile_cmd_entry; write transactions are scoreboarded against the we pulse.
// Abort scenario is included when CMD_ENTRY_ABORT_EN is defined.
module tb_regfile_cmd_entry;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   we_cnt;
    logic [20:0] wr_q[$];

    regfile_cmd_entry_if bus();

    regfile_cmd_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every we pulse pops one expected {wa,wd} pair pushed when the write was entered.
    always @(negedge clk) begin
        if (!rst && bus.we === 1'b1) begin
            logic [20:0] e;
            we_cnt  = we_cnt + 1;
            n_tests = n_tests + 1;
            if (wr_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_we: got we=1 wa=%0h wd=%0h, required no write", bus.wa, bus.wd);
            end else begin
                e = wr_q.pop_front();
                if ({bus.wa, bus.wd} !== e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL write_data: got wa=%0h wd=%0h, required wa=%0h wd=%0h",
                             bus.wa, bus.wd, e[20:16], e[15:0]);
                end
            end
        end
    end

    task automatic press(input logic [3:0] v);
        bus.sw = v;
        repeat (2) @(negedge clk);
        bus.btn = 1'b1;
        repeat (12) @(negedge clk);
        bus.btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

`ifdef CMD_ENTRY_ABORT_EN
    task automatic press_abort();
        repeat (2) @(negedge clk);
        bus.btn_abort = 1'b1;
        repeat (12) @(negedge clk);
        bus.btn_abort = 1'b0;
        repeat (12) @(negedge clk);
    endtask
`endif

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy, bus.we, bus.wa, bus.wd, bus.raA, bus.raB} !== 36'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_outputs: got mode=%0h busy=%0b we=%0b wa=%0h wd=%0h raA=%0h raB=%0h, required all 0",
                     bus.mode, bus.busy, bus.we, bus.wa, bus.wd, bus.raA, bus.raB);
        end
    endtask

    task automatic test_glitch();
        bus.sw = 4'h1;
        repeat (2) @(negedge clk);
        bus.btn = 1'b1;
        repeat (2) @(negedge clk);
        bus.btn = 1'b0;
        repeat (15) @(negedge clk);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy} !== 3'b000) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_ignored: got mode=%0h busy=%0b, required mode=0 busy=0", bus.mode, bus.busy);
        end
        n_tests = n_tests + 1;
        if ({bus.wa, bus.wd, bus.raA, bus.raB} !== 31'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_regs: got wa=%0h wd=%0h raA=%0h raB=%0h, required 0",
                     bus.wa, bus.wd, bus.raA, bus.raB);
        end
    endtask

    task automatic test_write();
        int we0;
        we0 = we_cnt;
        wr_q.push_back({5'h1A, 16'hBCDE});
        press(4'h1); press(4'h1); press(4'hA);
        press(4'hB); press(4'hC); press(4'hD); press(4'hE);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy} !== 3'b011) begin
            n_fail = n_fail + 1;
            $display("FAIL write_show: got mode=%0h busy=%0b, required mode=1 busy=1", bus.mode, bus.busy);
        end
        n_tests = n_tests + 1;
        if ({bus.wa, bus.wd} !== {5'h1A, 16'hBCDE}) begin
            n_fail = n_fail + 1;
            $display("FAIL write_regs: got wa=%0h wd=%0h, required wa=1a wd=bcde", bus.wa, bus.wd);
        end
        n_tests = n_tests + 1;
        if (we_cnt - we0 !== 1) begin
            n_fail = n_fail + 1;
            $display("FAIL write_we_count: got %0d pulses, required 1", we_cnt - we0);
        end
        press(4'h0);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy} !== 3'b000) begin
            n_fail = n_fail + 1;
            $display("FAIL write_return: got mode=%0h busy=%0b, required mode=0 busy=0", bus.mode, bus.busy);
        end
    endtask

    task automatic test_single_read();
        int we0;
        we0 = we_cnt;
        press(4'h2); press(4'h0); press(4'h7);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy, bus.raA} !== {2'b10, 1'b1, 5'h07}) begin
            n_fail = n_fail + 1;
            $display("FAIL single_read: got mode=%0h busy=%0b raA=%0h, required mode=2 busy=1 raA=07",
                     bus.mode, bus.busy, bus.raA);
        end
        n_tests = n_tests + 1;
        if ({bus.wa, bus.wd} !== {5'h1A, 16'hBCDE} || we_cnt != we0) begin
            n_fail = n_fail + 1;
            $display("FAIL single_read_stale: got wa=%0h wd=%0h we_pulses=%0d, required wa=1a wd=bcde we_pulses=0",
                     bus.wa, bus.wd, we_cnt - we0);
        end
        press(4'h0);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy} !== 3'b000) begin
            n_fail = n_fail + 1;
            $display("FAIL single_read_return: got mode=%0h busy=%0b, required 0/0", bus.mode, bus.busy);
        end
    endtask

    task automatic test_dual_read();
        press(4'h3); press(4'h1); press(4'hF); press(4'h0); press(4'h3);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.raA, bus.raB} !== {2'b11, 5'h1F, 5'h03}) begin
            n_fail = n_fail + 1;
            $display("FAIL dual_read: got mode=%0h raA=%0h raB=%0h, required mode=3 raA=1f raB=03",
                     bus.mode, bus.raA, bus.raB);
        end
        press(4'h0);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy} !== 3'b000) begin
            n_fail = n_fail + 1;
            $display("FAIL dual_read_return: got mode=%0h busy=%0b, required 0/0", bus.mode, bus.busy);
        end
    endtask

    task automatic test_opcode_zero();
        press(4'hC);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy, bus.raA, bus.raB} !== {2'b00, 1'b0, 5'h1F, 5'h03}) begin
            n_fail = n_fail + 1;
            $display("FAIL opcode_zero: got mode=%0h busy=%0b raA=%0h raB=%0h, required mode=0 busy=0 raA=1f raB=03",
                     bus.mode, bus.busy, bus.raA, bus.raB);
        end
    endtask

    task automatic test_reset_mid_write();
        int we0;
        we0 = we_cnt;
        press(4'h1); press(4'h0); press(4'h9);
        press(4'h1); press(4'h2); press(4'h3);
        n_tests = n_tests + 1;
        if (bus.busy !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL mid_write_busy: got busy=%0b, required 1", bus.busy);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        press(4'h4);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy, bus.wa, bus.wd} !== 24'd0 || we_cnt != we0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_mid_write: got mode=%0h busy=%0b wa=%0h wd=%0h we_pulses=%0d, required all 0",
                     bus.mode, bus.busy, bus.wa, bus.wd, we_cnt - we0);
        end
    endtask

`ifdef CMD_ENTRY_ABORT_EN
    task automatic test_abort();
        int we0;
        we0 = we_cnt;
        press(4'h1); press(4'h1); press(4'h6); press(4'h8); press(4'h9);
        press_abort();
        n_tests = n_tests + 1;
        if ({bus.mode, bus.busy} !== 3'b000 || we_cnt != we0) begin
            n_fail = n_fail + 1;
            $display("FAIL abort: got mode=%0h busy=%0b we_pulses=%0d, required 0/0/0",
                     bus.mode, bus.busy, we_cnt - we0);
        end
        n_tests = n_tests + 1;
        if ({bus.wa, bus.wd[15:8]} !== {5'h16, 8'h89}) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_partial: got wa=%0h wd=%0h, required wa=16 wd[15:8]=89", bus.wa, bus.wd);
        end
        wr_q.push_back({5'h05, 16'h1234});
        press(4'h1); press(4'h0); press(4'h5);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        n_tests = n_tests + 1;
        if ({bus.mode, bus.wa, bus.wd} !== {2'b01, 5'h05, 16'h1234} || we_cnt - we0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_then_write: got mode=%0h wa=%0h wd=%0h we_pulses=%0d, required mode=1 wa=05 wd=1234 we_pulses=1",
                     bus.mode, bus.wa, bus.wd, we_cnt - we0);
        end
        press_abort();
        n_tests = n_tests + 1;
        if (bus.mode !== 2'b01) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_in_show: got mode=%0h, required 1", bus.mode);
        end
        press(4'h0);
    endtask
`endif

    task automatic test_final();
        n_tests = n_tests + 1;
        if (wr_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL missing_we: got %0d writes outstanding, required 0", wr_q.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        we_cnt  = 0;
        rst     = 1'b1;
        bus.sw  = 4'h0;
        bus.btn = 1'b0;
`ifdef CMD_ENTRY_ABORT_EN
        bus.btn_abort = 1'b0;
`endif
        test_reset();
        test_glitch();
        test_write();
        test_single_read();
        test_dual_read();
        test_opcode_zero();
        test_reset_mid_write();
`ifdef CMD_ENTRY_ABORT_EN
        test_abort();
`endif
        test_final();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_cmd_entry.md
Name: regfile_cmd_entry

Overview:
- Input-side counterpart of the register-file LCD display path. Turns slide-switch nibbles and a single raw pushbutton into register-file commands: write, read one port, or read both ports.
- Drives the display mode code and the addresses and data the LCD output block renders: wa/wd, raA, plus raB for the second read port.
- Issues a one-cycle write-enable to the register file.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles the button level must differ from the debounced level before it is accepted; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- sw  input  4  slide switches, sampled on each accepted press
- btn  input  1  raw asynchronous pushbutton, active-high
- mode  output  2  display mode: 00 accepting, 01 write shown, 10 single read shown, 11 dual read shown
- wa  output  5  write address
- wd  output  16  write data
- raA  output  5  read address, port A
- raB  output  5  read address, port B
- we  output  1  register-file write enable, one-cycle pulse
- busy  output  1  high in any state other than S_ACCEPT

Behaviour:
- Reset: all outputs are 0 and the state is S_ACCEPT. Reset has priority in every state, including mid-entry: partial addresses and data are discarded and no write occurs.
- Button synchronizer and debouncer:
  - btn passes through two flops to give s.
  - Counter cnt clears whenever s equals the debounced level db.
  - While s differs from db, cnt increments. When cnt equals DEBOUNCE_CYCLES-1 and s still differs, db takes s and cnt clears.
  - A registered pulse press asserts for exactly one cycle, the cycle after db goes 0 to 1. A held button produces exactly one press.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no press.
- FSM: every transition below happens only on press, except S_WRITE.
  - S_ACCEPT: sw[1:0] is the opcode, latched into the internal op register.
    - 00: ignored; stay in S_ACCEPT.
    - Any non-zero opcode: go to S_A_HI.
  - S_A_HI: the target register (wa when op=01, else raA) takes bit 4 = sw[0]; go to S_A_LO.
  - S_A_LO: the same register takes bits 3:0 = sw.
    - op=01: go to S_D3.
    - op=10: go to S_SHOW_R1.
    - op=11: go to S_B_HI.
  - S_D3, S_D2, S_D1, S_D0: wd[15:12], wd[11:8], wd[7:4], wd[3:0] take sw in that order (most significant nibble first). S_D0 goes to S_WRITE.
  - S_WRITE: we=1 for this single cycle, with wa/wd already stable. Unconditionally go to S_SHOW_W on the next edge.
  - S_B_HI: raB[4] takes sw[0]; go to S_B_LO.
  - S_B_LO: raB[3:0] takes sw; go to S_SHOW_R2.
  - S_SHOW_W, S_SHOW_R1, S_SHOW_R2: the press takes no capture and returns to S_ACCEPT.
- Output rules:
  - Address and data registers update on the edge the press is consumed and hold until overwritten or reset. Stale values remain visible between operations.
  - mode is registered and changes on the same edge the FSM enters a state.
  - mode per state: 01 in S_WRITE and S_SHOW_W, 10 in S_SHOW_R1, 11 in S_SHOW_R2, 00 in all others.
  - we is 0 everywhere except S_WRITE.
- A press arriving while in S_WRITE is impossible: presses are at least DEBOUNCE_CYCLES+1 cycles apart.

Optional Feature:
- Macro: CMD_ENTRY_ABORT_EN.
- When defined:
  - Adds input btn_abort (1 bit, raw), with its own synchronizer and debouncer of the same parameter.
  - An abort press in any entry state (S_A_HI through S_D0, S_B_HI, S_B_LO) returns the FSM to S_ACCEPT with mode 00 and no we. Captured registers keep their partial values.
  - An abort press in S_ACCEPT, S_WRITE or a show state is ignored.
  - If abort and btn presses coincide in the same cycle, abort wins.
- When undefined: the port is absent and the FSM has no abort path.

Test Plan:
- Reset, then btn glitch high for 2 cycles (DEBOUNCE_CYCLES=4) -> no press pulse, mode=00, busy=0, all outputs 0.
- Write sequence, presses with sw=1,1,0xA,0xB,0xC,0xD,0xE -> wa=0x1A, wd=0xBCDE, single we pulse, mode=01. Next press -> mode=00, busy=0.
- Single read, presses with sw=2,0,0x7 -> raA=0x07, mode=10, we never asserted.
- Dual read, presses with sw=3,1,0xF,0,0x3 -> raA=0x1F, raB=0x03, mode=11.
- Opcode 00 press in S_ACCEPT -> state and mode unchanged. Reset asserted after the third data nibble of a write -> we never pulses, wa=wd=0, mode=00.
- CMD_ENTRY_ABORT_EN: abort after the second data nibble -> mode=00, busy=0, no we. A following full write completes normally.
